// File: rtl/intr_controller_pkg.sv
// intr_controller_pkg: shared I/O map and FSM encodings for the interrupt controller.
//   TIMER_BASE / INTC_BASE : device register window bases on the ABUS/DBUS bus
//   OFS_*                  : word index (ABUS[3:2]) of each controller register
//   ST_*                   : controller FSM encodings
//   winHit()               : true when an address is a word-aligned hit in a 16-byte window
package intr_controller_pkg;

    localparam logic [31:0] TIMER_BASE = 32'hFFFFF100;
    localparam logic [31:0] INTC_BASE  = 32'hFFFFF200;

    localparam logic [1:0] OFS_IPEND  = 2'd0;
    localparam logic [1:0] OFS_IMASK  = 2'd1;
    localparam logic [1:0] OFS_ICTL   = 2'd2;
    localparam logic [1:0] OFS_ICAUSE = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_SVC  = 2'd2;

    function automatic logic winHit(input logic [31:0] addr, input logic [31:0] base);
        return (addr[31:4] == base[31:4]) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// intr_prio_enc: combinational lowest-index-first priority encoder.
//   req : NSRC request bits (bit 0 has highest priority)
//   any : at least one request bit set
//   idx : index of the lowest set bit, 0 when none
module intr_prio_enc #(
    parameter int NSRC = 4
) (
    input  logic [NSRC-1:0] req,
    output logic            any,
    output logic [3:0]      idx
);

    assign any = |req;

    // Scanning from the top down lets the lowest set index overwrite the others.
    always_comb begin
        idx = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            idx = req[i] ? 4'(i) : idx;
    end

endmodule

// File: rtl/intr_controller.sv
// intr_controller: memory-mapped priority interrupt controller between I/O devices and the CPU.
//   CLK    : system clock
//   INIT   : asynchronous active-high reset
//   ABUS   : address bus; window at BASE (IPEND +0, IMASK +4, ICTL +8, ICAUSE +C)
//   DBUS   : shared data bus; driven only on reads of this window, else 'z
//   WE     : bus write enable (1 = write, 0 = read)
//   IRQ_IN : level requests from devices, synchronous to CLK; rising edges latch into IPEND
//   INTA   : CPU acknowledge pulse; takes the winner into service
//   IRET   : CPU return-from-interrupt pulse; ends service
//   INTR   : interrupt request to the CPU
//   IVEC   : id of the source in service
module intr_controller
    import intr_controller_pkg::*;
#(
    parameter int          NSRC = 4,
    parameter int          BITS = 32,
    parameter logic [31:0] BASE = INTC_BASE
) (
    input  logic            CLK,
    input  logic            INIT,
    input  logic [31:0]     ABUS,
    inout  wire  [BITS-1:0] DBUS,
    input  logic            WE,
    input  logic [NSRC-1:0] IRQ_IN,
    input  logic            INTA,
    input  logic            IRET,
    output logic            INTR,
    output logic [3:0]      IVEC
);

    if (NSRC < 1 || NSRC > 16) begin : gBadNsrc
        $error("intr_controller: NSRC must be 1..16 to fit the 4-bit IVEC");
    end

    logic [NSRC-1:0] ipend;
    logic [NSRC-1:0] imask;
    logic [NSRC-1:0] irqQ;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] eligible;
    logic [NSRC-1:0] w1c;
    logic [NSRC-1:0] ackClr;
    logic [1:0]      ictl;
    logic [1:0]      state;
    logic [1:0]      nextState;
    logic [1:0]      regSel;
    logic [3:0]      winner;
    logic            anyElig;
    logic            hit;
    logic            wrEn;
    logic            ack;
    logic [BITS-1:0] rdData;
    logic            unusedBus;

    assign hit      = winHit(ABUS, BASE);
    assign regSel   = ABUS[3:2];
    assign wrEn     = hit && WE;
    assign rise     = IRQ_IN & ~irqQ;
    assign eligible = ictl[0] ? (ipend & imask) : '0;

    intr_prio_enc #(.NSRC(NSRC)) uEnc (
        .req (eligible),
        .any (anyElig),
        .idx (winner)
    );

    assign ack    = (state == ST_REQ) && INTA && anyElig;
    assign w1c    = (wrEn && regSel == OFS_IPEND) ? DBUS[NSRC-1:0] : '0;
    assign ackClr = ack ? (NSRC'(1) << winner) : '0;

    // ICAUSE mirrors IVEC: both are loaded with the winner on acknowledge.
    always_comb
        rdData = (regSel == OFS_IPEND) ? BITS'(ipend) :
                 (regSel == OFS_IMASK) ? BITS'(imask) :
                 (regSel == OFS_ICTL)  ? BITS'(ictl)  : BITS'(IVEC);

    assign DBUS      = (hit && !WE) ? rdData : 'z;
    assign INTR      = (state == ST_REQ);
    assign unusedBus = ^DBUS;

    // REQ drops back to IDLE whenever nothing is eligible, even if INTA arrives.
    always_comb
        nextState = (state == ST_IDLE) ? (anyElig ? ST_REQ : ST_IDLE) :
                    (state == ST_REQ)  ? (!anyElig ? ST_IDLE : INTA ? ST_SVC : ST_REQ) :
                    (state == ST_SVC)  ? (IRET ? ST_IDLE : ST_SVC) : ST_IDLE;

    always_ff @(posedge CLK or posedge INIT) begin
        if (INIT) begin
            irqQ  <= '0;
            ipend <= '0;
            imask <= '0;
            ictl  <= '0;
            IVEC  <= '0;
            state <= ST_IDLE;
        end else begin
            irqQ  <= IRQ_IN;
            // A fresh rise is OR-ed in last so it beats both W1C and acknowledge clears.
            ipend <= (ipend & ~w1c & ~ackClr) | rise;
            if (wrEn && regSel == OFS_IMASK)
                imask <= DBUS[NSRC-1:0];
            if (wrEn && regSel == OFS_ICTL)
                ictl <= DBUS[1:0];
            if (ack)
                IVEC <= winner;
            state <= nextState;
        end
    end

endmodule

// File: tb/tb_intr_controller.sv
// tb_intr_controller: directed and randomized checks of intr_controller against a behavioural model.
`timescale 1ns/1ps
module tb_intr_controller;

    localparam int          N    = 4;
    localparam logic [31:0] BASE = 32'hFFFFF200;

    logic          CLK = 1'b0;
    logic          INIT = 1'b1;
    logic          WE = 1'b0;
    logic          INTA = 1'b0;
    logic          IRET = 1'b0;
    logic [31:0]   ABUS = 32'h0;
    logic [31:0]   dbDrv = 32'h0;
    logic          dbEn = 1'b0;
    logic [N-1:0]  IRQ_IN = '0;
    tri1  [31:0]   DBUS;
    logic          INTR;
    logic [3:0]    IVEC;

    assign DBUS = dbEn ? dbDrv : 'z;

    intr_controller #(.NSRC(N), .BITS(32), .BASE(BASE)) dut (
        .CLK    (CLK),
        .INIT   (INIT),
        .ABUS   (ABUS),
        .DBUS   (DBUS),
        .WE     (WE),
        .IRQ_IN (IRQ_IN),
        .INTA   (INTA),
        .IRET   (IRET),
        .INTR   (INTR),
        .IVEC   (IVEC)
    );

    always #10 CLK = ~CLK;

    int total = 0;
    int bad = 0;

    // Behavioural model: pending/mask flags per source, and whether the CPU is
    // currently being asked (asking) or is running a handler (serving).
    bit pend[N];
    bit msk[N];
    bit ie, nest, asking, serving;
    bit [N-1:0] lastIrq;
    int cause;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int regIndex(input logic [31:0] a);
        for (int k = 0; k < 4; k++)
            if (a == BASE + 32'(4 * k)) return k;
        return -1;
    endfunction

    function automatic logic [31:0] regVal(input int k);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < N; i++) begin
            if (k == 0) v[i] = pend[i];
            if (k == 1) v[i] = msk[i];
        end
        if (k == 2) v = {30'h0, nest, ie};
        if (k == 3) v = 32'(cause);
        return v;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            msk[i]  = 1'b0;
        end
        ie = 0; nest = 0; asking = 0; serving = 0; lastIrq = '0; cause = 0;
    endtask

    task automatic modelAdvance();
        int win;
        int k;
        bit np[N];
        if (INIT) begin
            modelReset();
            return;
        end
        win = -1;
        for (int i = 0; i < N; i++)
            if (win < 0 && ie && pend[i] && msk[i]) win = i;
        k = (WE && dbEn) ? regIndex(ABUS) : -1;
        np = pend;
        for (int i = 0; i < N; i++) begin
            if (k == 0 && dbDrv[i]) np[i] = 1'b0;
            if (asking && INTA && win == i) np[i] = 1'b0;
            if (IRQ_IN[i] && !lastIrq[i]) np[i] = 1'b1;
        end
        if (k == 1)
            for (int i = 0; i < N; i++) msk[i] = dbDrv[i];
        if (k == 2) begin
            ie   = dbDrv[0];
            nest = dbDrv[1];
        end
        if (serving)
            serving = !IRET;
        else if (asking) begin
            if (win < 0)
                asking = 0;
            else if (INTA) begin
                asking  = 0;
                serving = 1;
                cause   = win;
            end
        end else
            asking = (win >= 0);
        pend = np;
        lastIrq = IRQ_IN;
    endtask

    task automatic tick();
        @(posedge CLK);
        modelAdvance();
        #1;
    endtask

    task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
        ABUS = a; WE = 1'b1; dbEn = 1'b1; dbDrv = d;
        tick();
        WE = 1'b0; dbEn = 1'b0; ABUS = 32'h0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        ABUS = a;
        #1;
        v = DBUS;
        ABUS = 32'h0;
    endtask

    task automatic pulseInta();
        INTA = 1'b1; tick(); INTA = 1'b0;
    endtask

    task automatic pulseIret();
        IRET = 1'b1; tick(); IRET = 1'b0;
    endtask

    // Cycle-by-cycle comparison of every observable output against the model.
    always @(negedge CLK) begin
        int k;
        logic [31:0] expBus;
        k = regIndex(ABUS);
        expBus = dbEn ? dbDrv : (k >= 0 && !WE) ? regVal(k) : 32'hFFFFFFFF;
        chk("cyc INTR", 32'(INTR), 32'(asking));
        chk("cyc IVEC", 32'(IVEC), 32'(cause));
        chk("cyc DBUS", DBUS, expBus);
    end

    initial begin
        logic [31:0] v;
        modelReset();
        tick();
        tick();
        INIT = 1'b0;
        chk("rst INTR", 32'(INTR), 32'h0);
        chk("rst IVEC", 32'(IVEC), 32'h0);
        for (int k = 0; k < 4; k++) begin
            rd(BASE + 32'(4 * k), v);
            chk("rst reg", v, 32'h0);
        end

        // single source round trip
        busWrite(BASE + 4, 32'hF);
        busWrite(BASE + 8, 32'h1);
        IRQ_IN = 4'b0001;
        tick();
        chk("t1 INTR n+1", 32'(INTR), 32'h0);
        IRQ_IN = 4'b0000;
        tick();
        chk("t1 INTR n+2", 32'(INTR), 32'h1);
        pulseInta();
        chk("t1 IVEC", 32'(IVEC), 32'h0);
        chk("t1 INTR svc", 32'(INTR), 32'h0);
        rd(BASE, v);
        chk("t1 IPEND", v, 32'h0);
        pulseIret();
        tick();
        chk("t1 INTR idle", 32'(INTR), 32'h0);

        // two simultaneous sources, priority and re-arbitration gap
        IRQ_IN = 4'b0110;
        tick();
        tick();
        chk("t2 INTR", 32'(INTR), 32'h1);
        pulseInta();
        chk("t2 IVEC a", 32'(IVEC), 32'h1);
        rd(BASE, v);
        chk("t2 IPEND", v, 32'h4);
        chk("t2 mdl pend", regVal(0), 32'h4);
        pulseIret();
        chk("t2 INTR gap", 32'(INTR), 32'h0);
        tick();
        chk("t2 INTR again", 32'(INTR), 32'h1);
        pulseInta();
        chk("t2 IVEC b", 32'(IVEC), 32'h2);
        chk("t2 mdl cause", 32'(cause), 32'h2);

        // ICAUSE read, unmapped read, ignored ICAUSE write
        rd(BASE + 32'hC, v);
        chk("t5 ICAUSE", v, 32'h2);
        rd(BASE + 32'h10, v);
        chk("t5 unmapped", v, 32'hFFFFFFFF);
        busWrite(BASE + 32'hC, 32'h7);
        rd(BASE + 32'hC, v);
        chk("t5 ICAUSE wr", v, 32'h2);
        IRQ_IN = 4'b0000;
        pulseIret();

        // masked source stays pending until unmasked
        busWrite(BASE + 4, 32'hE);
        IRQ_IN = 4'b0001;
        tick();
        IRQ_IN = 4'b0000;
        tick();
        chk("t3 INTR masked", 32'(INTR), 32'h0);
        rd(BASE, v);
        chk("t3 IPEND", v, 32'h1);
        busWrite(BASE + 4, 32'hF);
        tick();
        chk("t3 INTR unmask", 32'(INTR), 32'h1);

        // W1C while requesting, then W1C racing a new edge
        busWrite(BASE, 32'h1);
        chk("t4 INTR hold", 32'(INTR), 32'h1);
        tick();
        chk("t4 INTR drop", 32'(INTR), 32'h0);
        chk("t4 mdl asking", 32'(asking), 32'h0);
        IRQ_IN = 4'b0001;
        busWrite(BASE, 32'h1);
        IRQ_IN = 4'b0000;
        rd(BASE, v);
        chk("t4 rise wins", v, 32'h1);
        tick();
        chk("t4 INTR", 32'(INTR), 32'h1);

        // asynchronous reset in the middle of service
        pulseInta();
        IRQ_IN = 4'b1000;
        tick();
        IRQ_IN = 4'b0000;
        INIT = 1'b1;
        modelReset();
        #1;
        chk("t6 INTR", 32'(INTR), 32'h0);
        chk("t6 IVEC", 32'(IVEC), 32'h0);
        for (int k = 0; k < 4; k++) begin
            rd(BASE + 32'(4 * k), v);
            chk("t6 reg", v, 32'h0);
        end
        tick();
        INIT = 1'b0;
        busWrite(BASE + 4, 32'hF);
        busWrite(BASE + 8, 32'h1);

        // randomized traffic checked every cycle by the compare process
        for (int c = 0; c < 3000; c++) begin
            int r;
            INIT = 1'b0;
            WE = 1'b0; dbEn = 1'b0;
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 3) == 0) IRQ_IN = 4'($urandom);
            INTA = ($urandom_range(0, 4) == 0);
            IRET = ($urandom_range(0, 6) == 0);
            case ($urandom_range(0, 6))
                0, 1, 2, 3: ABUS = BASE + 32'(4 * $urandom_range(0, 3));
                4:          ABUS = BASE + 32'h10;
                5:          ABUS = 32'hFFFFF100;
                default:    ABUS = $urandom;
            endcase
            if (r < 15) begin
                WE = 1'b1; dbEn = 1'b1; dbDrv = $urandom;
                if (ABUS == BASE + 8) dbDrv[0] = ($urandom_range(0, 4) != 0);
            end
            if ($urandom_range(0, 499) == 0) begin
                INIT = 1'b1;
                modelReset();
            end
            tick();
        end
        WE = 1'b0; dbEn = 1'b0; INTA = 1'b0; IRET = 1'b0; INIT = 1'b0; ABUS = 32'h0;
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
